bch_error_two: RTL

//  Reduced Chien search for BCH codes with T>=2 when at most two bit errors must be located.
//  - Evaluates a degree<=2 error locator over every data-bit position, BITS positions per cycle.
//  - Sits between the key-equation solver and the data correction XOR stage.
//  - Adds a start/ready handshake, an explicit data window, a per-word error count and a decoder-failure flag.

---
 rtl/bch_error_two.sv | 176 +++++++++++++++++
 1 files changed

// File: rtl/bch_error_two.sv
// Reduced Chien search locating up to two bit errors from a degree<=2 locator, BITS positions per cycle.
// Define BCH_ERROR_TWO_FAIL_EN to build the per-word error count and decoder-failure flag.
//
// Handshake: start is accepted on a rising clk edge only while ready=1; each accepted word then
// produces exactly BEATS back-to-back valid beats, with no output backpressure.
module bch_error_two #(
  parameter int M               = 4,
  parameter int DATA_BITS       = 7,
  parameter int SKIP            = 8,
  parameter int BITS            = 1,
  parameter int PIPELINE_STAGES = 0
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  output logic            ready,
  input  logic [2*M-1:0]  sigma,
  output logic            valid,
  output logic            first,
  output logic            last,
  output logic [BITS-1:0] err,
  output logic [1:0]      err_count,
  output logic            fail,
  output logic            dbg_state_o
);

  localparam int BEATS = (DATA_BITS + BITS - 1) / BITS;
  localparam int CW    = $clog2(BEATS) + 1;
  localparam int N     = (1 << M) - 1;
  localparam int PW    = BITS + 6;

  function automatic int field_poly(input int m);
    case (m)
      2:       return 'b111;
      3:       return 'b1011;
      5:       return 'b100101;
      6:       return 'b1000011;
      7:       return 'b10001001;
      8:       return 'b100011101;
      default: return 'b10011;
    endcase
  endfunction

  localparam int            FIELD_POLY = field_poly(M);
  localparam logic [M-1:0]  POLY_LO    = FIELD_POLY[M-1:0];

  // Multiply by the constant alpha^k; k is always elaboration-time constant, so this is an XOR network.
  function automatic logic [M-1:0] mul_pow(input logic [M-1:0] v, input int k);
    logic [M-1:0] r;
    int           kk;
    r  = v;
    kk = k % N;
    for (int i = 0; i < N; i++) begin
      if (i < kk) r = {r[M-2:0], 1'b0} ^ (r[M-1] ? POLY_LO : '0);
    end
    return r;
  endfunction

  localparam logic [M-1:0] TERM2_INIT = mul_pow(M'(1), 2 * SKIP);

  typedef enum logic {IDLE = 1'b0, SEARCH = 1'b1} state_t;

  state_t         state_q;
  logic           ready_q;
  logic [CW-1:0]  beat_q;
  logic [M-1:0]   sig2_q;
  logic [M-1:0]   term1_q;
  logic [M-1:0]   term2_q;

  logic            accept;
  logic            is_first;
  logic            is_last;
  logic [BITS-1:0] hit;
  logic [1:0]      cnt_d;
  logic            fail_d;
  logic [PW-1:0]   stage_d;
  logic [PW-1:0]   pipe_q [PIPELINE_STAGES+1];

  assign accept      = (state_q == IDLE) && start && ready_q;
  assign is_first    = (beat_q == '0);
  assign is_last     = (beat_q == CW'(BEATS - 1));
  assign ready       = ready_q;
  assign dbg_state_o = state_q;

  // term1 tracks sig1*B and term2 tracks B^2, so a root is term2 ^ term1 ^ sig2 == 0.
  always_comb begin
    hit = '0;
    for (int b = 0; b < BITS; b++) begin
      if (int'(beat_q) * BITS + b < DATA_BITS)
        hit[b] = ((mul_pow(term1_q, b) ^ mul_pow(term2_q, 2 * b) ^ sig2_q) == '0);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      ready_q <= 1'b1;
      beat_q  <= '0;
      sig2_q  <= '0;
      term1_q <= '0;
      term2_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            sig2_q  <= sigma[2*M-1:M];
            term1_q <= mul_pow(sigma[M-1:0], SKIP);
            term2_q <= TERM2_INIT;
            beat_q  <= '0;
            ready_q <= 1'b0;
            state_q <= SEARCH;
          end else begin
            ready_q <= 1'b1;
          end
        end
        SEARCH: begin
          term1_q <= mul_pow(term1_q, BITS);
          term2_q <= mul_pow(term2_q, 2 * BITS);
          beat_q  <= beat_q + CW'(1);
          ready_q <= 1'b0;
          if (is_last) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

`ifdef BCH_ERROR_TWO_FAIL_EN
  logic [1:0] cnt_q;
  logic [1:0] deg_q;
  logic [1:0] cnt_next;

  always_comb begin
    int sum;
    sum = int'(cnt_q);
    for (int b = 0; b < BITS; b++) sum += hit[b] ? 1 : 0;
    cnt_next = (sum > 3) ? 2'd3 : 2'(sum);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
      deg_q <= '0;
    end else if (accept) begin
      cnt_q <= '0;
      deg_q <= (sigma[2*M-1:M] != '0) ? 2'd2 : ((sigma[M-1:0] != '0) ? 2'd1 : 2'd0);
    end else if (state_q == SEARCH) begin
      cnt_q <= cnt_next;
    end
  end

  assign cnt_d  = is_last ? cnt_next : 2'd0;
  assign fail_d = is_last && (cnt_next != deg_q);
`else
  assign cnt_d  = 2'd0;
  assign fail_d = 1'b0;
`endif

  always_comb begin
    stage_d = '0;
    if (state_q == SEARCH) stage_d = {1'b1, is_first, is_last, hit, cnt_d, fail_d};
  end

  // Stage 0 is the base output register; further stages only add latency.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i <= PIPELINE_STAGES; i++) pipe_q[i] <= '0;
    end else begin
      pipe_q[0] <= stage_d;
      for (int i = 1; i <= PIPELINE_STAGES; i++) pipe_q[i] <= pipe_q[i-1];
    end
  end

  assign {valid, first, last, err, err_count, fail} = pipe_q[PIPELINE_STAGES];

endmodule
